// File: rtl/lenet_conv_engine.sv
// Time-multiplexed zero-padded KxK convolution engine, one MAC per cycle.
// Buffers one CIN-channel input map, then streams COUT output maps.
module lenet_conv_engine #(
  parameter int DATA_W = 16,
  parameter int IN_DIM = 28,
  parameter int K      = 5,
  parameter int PAD    = 2,
  parameter int CIN    = 1,
  parameter int COUT   = 2,
  parameter int FRAC_W = 0,
  localparam int NW    = COUT * CIN * K * K,
  localparam int WA_W  = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_relu,
  input  logic                     wt_we,
  input  logic [WA_W-1:0]          wt_addr,
  input  logic signed [DATA_W-1:0] wt_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     busy
);
  localparam int OUT_DIM = IN_DIM + 2*PAD - K + 1;
  localparam int NP    = CIN * IN_DIM * IN_DIM;
  localparam int PA_W  = (NP > 1) ? $clog2(NP) : 1;
  localparam int ACC_W = 2*DATA_W + $clog2(K*K*CIN);
  localparam int PW    = 2*DATA_W;
  localparam int CIW   = $clog2(CIN + 1);
  localparam int COW   = $clog2(COUT + 1);
  localparam int KW    = $clog2(K + 1);
  localparam int OW    = $clog2(OUT_DIM + 1);
  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {S_LOAD, S_COMP, S_EMIT} state_t;

  state_t r_state;
  state_t w_next;

  logic signed [DATA_W-1:0] r_pix [NP];
  logic signed [DATA_W-1:0] r_wt  [NW];

  logic [PA_W-1:0]          r_lcnt;
  logic [CIW-1:0]           r_ci;
  logic [KW-1:0]            r_ky;
  logic [KW-1:0]            r_kx;
  logic [COW-1:0]           r_co;
  logic [OW-1:0]            r_oy;
  logic [OW-1:0]            r_ox;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_out;
  logic                     r_relu;

  logic                     w_in_fire;
  logic                     w_out_fire;
  logic                     w_last_in;
  logic                     w_first_tap;
  logic                     w_last_tap;
  logic                     w_last_px;
  logic                     w_pad;
  int                       w_iy;
  int                       w_ix;
  logic [PA_W-1:0]          w_paddr;
  logic [WA_W-1:0]          w_waddr;
  logic signed [DATA_W-1:0] w_pix;
  logic signed [DATA_W-1:0] w_wt;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_shr;
  logic signed [DATA_W-1:0] w_sat;
  logic signed [DATA_W-1:0] w_res;

  assign busy       = (r_state != S_LOAD);
  assign in_ready   = (r_state == S_LOAD) & ~reset;
  assign out_valid  = (r_state == S_EMIT);
  assign out_data   = r_out;
  assign out_last   = out_valid & w_last_px;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_last_in  = (r_lcnt == PA_W'(NP-1));

  assign w_first_tap = (r_ci == '0) && (r_ky == '0) && (r_kx == '0);
  assign w_last_tap  = (r_ci == CIW'(CIN-1)) &&
                       (r_ky == KW'(K-1)) &&
                       (r_kx == KW'(K-1));
  assign w_last_px   = (r_co == COW'(COUT-1)) &&
                       (r_oy == OW'(OUT_DIM-1)) &&
                       (r_ox == OW'(OUT_DIM-1));

  // Tap coordinates in the unpadded map; out-of-range taps read as zero.
  always_comb begin
    w_iy    = int'(r_oy) + int'(r_ky) - PAD;
    w_ix    = int'(r_ox) + int'(r_kx) - PAD;
    w_pad   = (w_iy < 0) || (w_iy >= IN_DIM) ||
              (w_ix < 0) || (w_ix >= IN_DIM);
    w_paddr = w_pad ? '0 :
              PA_W'((int'(r_ci) * IN_DIM + w_iy) * IN_DIM + w_ix);
    w_waddr = WA_W'(((int'(r_co) * CIN + int'(r_ci)) * K +
              int'(r_ky)) * K + int'(r_kx));
    w_pix   = w_pad ? '0 : r_pix[w_paddr];
    w_wt    = r_wt[w_waddr];
    w_prod  = PW'(w_pix) * PW'(w_wt);
    w_base  = w_first_tap ? '0 : r_acc;
    w_sum   = w_base + ACC_W'(w_prod);
    w_shr   = w_sum >>> FRAC_W;
    if (w_shr > SMAX) begin
      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (w_shr < SMIN) begin
      w_sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      w_sat = w_shr[DATA_W-1:0];
    end
    w_res = (r_relu && w_sat[DATA_W-1]) ? '0 : w_sat;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD: if (w_in_fire && w_last_in) w_next = S_COMP;
      S_COMP: if (w_last_tap) w_next = S_EMIT;
      S_EMIT: if (w_out_fire) w_next = w_last_px ? S_LOAD : S_COMP;
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_next;
  end

  // Buffers are deliberately left out of reset so weights survive it.
  always_ff @(posedge clk) begin
    if (w_in_fire)      r_pix[r_lcnt] <= in_data;
    if (wt_we && !busy) r_wt[wt_addr] <= wt_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lcnt <= '0;
      r_ci   <= '0;
      r_ky   <= '0;
      r_kx   <= '0;
      r_co   <= '0;
      r_oy   <= '0;
      r_ox   <= '0;
      r_acc  <= '0;
      r_out  <= '0;
      r_relu <= 1'b0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            if (r_lcnt == '0) r_relu <= cfg_relu;
            r_lcnt <= w_last_in ? '0 : r_lcnt + PA_W'(1);
          end
        end
        S_COMP: begin
          r_acc <= w_sum;
          if (w_last_tap) r_out <= w_res;
          if (r_kx == KW'(K-1)) begin
            r_kx <= '0;
            if (r_ky == KW'(K-1)) begin
              r_ky <= '0;
              r_ci <= (r_ci == CIW'(CIN-1)) ? '0 : r_ci + CIW'(1);
            end else begin
              r_ky <= r_ky + KW'(1);
            end
          end else begin
            r_kx <= r_kx + KW'(1);
          end
        end
        S_EMIT: begin
          if (w_out_fire) begin
            if (r_ox == OW'(OUT_DIM-1)) begin
              r_ox <= '0;
              if (r_oy == OW'(OUT_DIM-1)) begin
                r_oy <= '0;
                r_co <= (r_co == COW'(COUT-1)) ? '0 : r_co + COW'(1);
              end else begin
                r_oy <= r_oy + OW'(1);
              end
            end else begin
              r_ox <= r_ox + OW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
